// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for the fetch queue: default depth, bubble instruction and entry layout.
// The decoder imports NOP_INST from here so both sides agree on the bubble encoding.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH = 8;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int unsigned ENTRY_W  = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst);
        fq_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x 64 register array, two write ports, two asynchronous read ports.
// Contents are intentionally not reset; validity is tracked by the owner's count.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_a,
    input  logic [AW-1:0]      waddr_a,
    input  logic [ENTRY_W-1:0] wdata_a,
    input  logic               we_b,
    input  logic [AW-1:0]      waddr_b,
    input  logic [ENTRY_W-1:0] wdata_b,
    input  logic [AW-1:0]      raddr_a,
    output logic [ENTRY_W-1:0] rdata_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [ENTRY_W-1:0] rdata_b
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write addresses are always tail and tail+1, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[waddr_a] <= wdata_a;
        end
        if (we_b) begin
            mem[waddr_b] <= wdata_b;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue between the fetch stage and the decoder.
// Pushes and pops up to two entries per cycle; flush discards everything on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FQ_DEPTH,
    parameter logic [31:0] NOP    = NOP_INST,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [31:0]      in_instA,
    input  logic [31:0]      in_instB,
    input  logic [31:0]      in_pcA,
    input  logic [31:0]      in_pcB,
    output logic             in_ready,
    output logic [31:0]      out_instA,
    output logic [31:0]      out_instB,
    output logic [31:0]      out_pcA,
    output logic [31:0]      out_pcB,
    output logic             out_validA,
    output logic             out_validB,
    input  logic             dec_ready,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         push_n;
    logic [1:0]         pop_n;
    logic               push_en;
    logic               we_a;
    logic               we_b;
    logic [ENTRY_W-1:0] rdata_a;
    logic [ENTRY_W-1:0] rdata_b;
    fq_entry_t          ent_a;
    fq_entry_t          ent_b;

    // Ready looks only at registered occupancy so it never depends on this cycle's pop.
    assign in_ready   = count_q <= CNT_W'(DEPTH - 2);
    assign out_validA = count_q != '0;
    assign out_validB = count_q >= CNT_W'(2);
    assign push_en    = in_ready & ~flush;

    // Slot B alone (2'b10) is not a legal fetch group and pushes nothing.
    always_comb begin
        push_n = 2'd0;
        if (in_valid[0]) begin
            push_n = in_valid[1] ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (dec_ready && !flush) begin
            pop_n = {1'b0, out_validA} + {1'b0, out_validB};
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q;
        count_d = count_q - CNT_W'(pop_n);
        if (push_en) begin
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_d + CNT_W'(push_n);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign we_a = push_en & in_valid[0];
    assign we_b = we_a & in_valid[1];

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_a    (we_a),
        .waddr_a (tail_q),
        .wdata_a (make_entry(in_pcA, in_instA)),
        .we_b    (we_b),
        .waddr_b (tail_q + PTR_W'(1)),
        .wdata_b (make_entry(in_pcB, in_instB)),
        .raddr_a (head_q),
        .rdata_a (rdata_a),
        .raddr_b (head_q + PTR_W'(1)),
        .rdata_b (rdata_b)
    );

    assign ent_a = fq_entry_t'(rdata_a);
    assign ent_b = fq_entry_t'(rdata_b);

    // Stale storage is masked so the decoder sees a clean bubble in empty slots.
    assign out_instA = out_validA ? ent_a.inst : NOP;
    assign out_pcA   = out_validA ? ent_a.pc   : 32'h0;
    assign out_instB = out_validB ? ent_b.inst : NOP;
    assign out_pcB   = out_validB ? ent_b.pc   : 32'h0;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against hand-computed values and a small queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_instA, in_instB, in_pcA, in_pcB;
    logic        in_ready;
    logic [31:0] out_instA, out_instB, out_pcA, out_pcB;
    logic        out_validA, out_validB;
    logic        dec_ready;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] next_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instA   (in_instA),
        .in_instB   (in_instB),
        .in_pcA     (in_pcA),
        .in_pcB     (in_pcB),
        .in_ready   (in_ready),
        .out_instA  (out_instA),
        .out_instB  (out_instB),
        .out_pcA    (out_pcA),
        .out_pcB    (out_pcB),
        .out_validA (out_validA),
        .out_validB (out_validB),
        .dec_ready  (dec_ready),
        .count      (count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A00_0033;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pa, input logic [31:0] pb,
                         input logic dr, input logic fl);
        in_valid  = v;
        in_pcA    = pa;
        in_instA  = inst_of(pa);
        in_pcB    = pb;
        in_instB  = inst_of(pb);
        dec_ready = dr;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full visible state for a queue holding cnt entries whose two oldest PCs are pa, pb.
    task automatic check_head(input string tag, input int cnt, input logic [31:0] pa,
                              input logic [31:0] pb);
        check_eq({tag, " count"}, 64'(count), 64'(cnt));
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'((DEPTH - cnt) >= 2));
        check_eq({tag, " validA"}, 64'(out_validA), 64'(cnt >= 1));
        check_eq({tag, " validB"}, 64'(out_validB), 64'(cnt >= 2));
        check_eq({tag, " pcA"}, 64'(out_pcA), 64'((cnt >= 1) ? pa : 32'h0));
        check_eq({tag, " instA"}, 64'(out_instA), 64'((cnt >= 1) ? inst_of(pa) : NOP));
        check_eq({tag, " pcB"}, 64'(out_pcB), 64'((cnt >= 2) ? pb : 32'h0));
        check_eq({tag, " instB"}, 64'(out_instB), 64'((cnt >= 2) ? inst_of(pb) : NOP));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  v;
        logic        dr;
        logic        ready;
        int          npop;
        logic [31:0] pa, pb;

        rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check_head("reset", 0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // First pair; nothing visible before the edge.
        in_valid = 2'b11;
        in_instA = 32'h0010_0093;
        in_instB = 32'h0020_0113;
        in_pcA   = 32'h0;
        in_pcB   = 32'h4;
        #1;
        check_eq("no_bypass validA", 64'(out_validA), 64'(0));
        check_eq("no_bypass count", 64'(count), 64'(0));
        tick();
        check_eq("first validA", 64'(out_validA), 64'(1));
        check_eq("first validB", 64'(out_validB), 64'(1));
        check_eq("first instA", 64'(out_instA), 64'(32'h0010_0093));
        check_eq("first instB", 64'(out_instB), 64'(32'h0020_0113));
        check_eq("first pcA", 64'(out_pcA), 64'(32'h0));
        check_eq("first pcB", 64'(out_pcB), 64'(32'h4));
        check_eq("first count", 64'(count), 64'(2));

        // Fill with pairs while the decoder stalls.
        drive(2'b11, 32'h8, 32'hC, 1'b0, 1'b0);
        tick();
        check_eq("fill4 count", 64'(count), 64'(4));
        drive(2'b11, 32'h10, 32'h14, 1'b0, 1'b0);
        tick();
        check_eq("fill6 count", 64'(count), 64'(6));
        check_eq("fill6 in_ready", 64'(in_ready), 64'(1));
        drive(2'b11, 32'h18, 32'h1C, 1'b0, 1'b0);
        tick();
        check_eq("fill8 count", 64'(count), 64'(8));
        check_eq("fill8 in_ready", 64'(in_ready), 64'(0));
        drive(2'b11, 32'hF00, 32'hF04, 1'b0, 1'b0);
        tick();
        check_eq("full ignore count", 64'(count), 64'(8));
        check_eq("full keep instA", 64'(out_instA), 64'(32'h0010_0093));
        check_eq("full keep pcB", 64'(out_pcB), 64'(32'h4));

        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_head("pop_full", 6, 32'h8, 32'hC);
        drive(2'b01, 32'h100, 32'h104, 1'b0, 1'b0);
        tick();
        check_head("single7", 7, 32'h8, 32'hC);
        drive(2'b11, 32'hF10, 32'hF14, 1'b0, 1'b0);
        tick();
        check_head("full7 ignore", 7, 32'h8, 32'hC);

        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_head("drain5", 5, 32'h10, 32'h14);
        tick();
        check_head("drain3", 3, 32'h18, 32'h1C);

        // Push two and pop two in one cycle.
        drive(2'b11, 32'h200, 32'h204, 1'b1, 1'b0);
        tick();
        check_head("push_pop", 3, 32'h100, 32'h200);

        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_head("one_left", 1, 32'h204, 32'h0);
        tick();
        check_head("empty", 0, 32'h0, 32'h0);
        tick();
        check_head("empty_pop", 0, 32'h0, 32'h0);
        drive(2'b10, 32'h240, 32'h244, 1'b0, 1'b0);
        tick();
        check_head("only_b", 0, 32'h0, 32'h0);

        // Flush with push and pop in the same cycle.
        drive(2'b11, 32'h300, 32'h304, 1'b0, 1'b0);
        tick();
        drive(2'b11, 32'h308, 32'h30C, 1'b0, 1'b0);
        tick();
        drive(2'b01, 32'h310, 32'h314, 1'b0, 1'b0);
        tick();
        check_head("pre_flush", 5, 32'h300, 32'h304);
        drive(2'b11, 32'h400, 32'h404, 1'b1, 1'b1);
        tick();
        check_head("flush", 0, 32'h0, 32'h0);
        drive(2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
        tick();
        check_head("post_flush", 2, 32'h500, 32'h504);

        // Random traffic against a FIFO model; pointers wrap several times.
        mq      = '{32'h500, 32'h504};
        next_pc = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            pa = (mq.size() > 0) ? mq[0] : 32'h0;
            pb = (mq.size() > 1) ? mq[1] : 32'h0;
            check_head($sformatf("rnd%0d", i), mq.size(), pa, pb);
            v  = 2'($urandom_range(0, 3));
            dr = 1'($urandom_range(0, 1));
            drive(v, next_pc, next_pc + 32'h4, dr, 1'b0);
            tick();
            ready = (DEPTH - mq.size()) >= 2;
            npop  = dr ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
            repeat (npop) void'(mq.pop_front());
            if (ready && v[0]) begin
                mq.push_back(next_pc);
                next_pc += 32'h4;
                if (v[1]) begin
                    mq.push_back(next_pc);
                    next_pc += 32'h4;
                end
            end
        end

        // Make sure the queue is occupied, then reset asynchronously between edges.
        drive(2'b01, next_pc, next_pc + 32'h4, 1'b0, 1'b0);
        ready = (DEPTH - mq.size()) >= 2;
        tick();
        if (ready) begin
            mq.push_back(next_pc);
            next_pc += 32'h4;
        end
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        pa = (mq.size() > 0) ? mq[0] : 32'h0;
        pb = (mq.size() > 1) ? mq[1] : 32'h0;
        check_head("pre_reset", mq.size(), pa, pb);
        #2;
        rst_n = 1'b0;
        #1;
        check_head("async_reset", 0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(2'b11, 32'h700, 32'h704, 1'b0, 1'b0);
        tick();
        check_head("after_reset", 2, 32'h700, 32'h704);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
